ad9833_serial_rx: RTL
=====================

// Module: ad9833_serial_rx
// PURPOSE
//   Receiving end of the AD9833 3-wire interface (fsync/sclk/sdata). Oversamples the
//   bus on the system clock, assembles 16-bit words and decodes them into a shadow of
//   the AD9833 register file: control, FREQ0/1, PHASE0/1.
//   Used as loopback checker/monitor beside the embedded-system AD9833 driver, and as
//   the DAC model in simulation.
// PARAMETERS
//   SYNC_STAGES  2   synchronizer flops on fsync/sclk/sdata (min 2)
// PORTS
//   clk          in   1   system clock (50 MHz)
//   rst          in   1   reset (one clock; synchronous, active-high)
//   fsync        in   1   frame sync, active low, asynchronous to clk
//   sclk         in   1   serial clock; data sampled on falling edge; async to clk
//   sdata        in   1   serial data, MSB first, async to clk
//   word         out  16  last complete word received
//   word_valid   out  1   1-cycle pulse: word updated
//   frame_err    out  1   1-cycle pulse: fsync rose with 1..15 bits captured
//   ctrl_reg     out  16  last control word (D15:D14=00)
//   freq0        out  28  FREQ0 register
//   freq1        out  28  FREQ1 register
//   phase0       out  12  PHASE0 register
//   phase1       out  12  PHASE1 register
// BEHAVIOUR
//   - Reset: all outputs 0; bit counter 0; B28 half-flags cleared; sync flops set to
//     fsync=1, sclk=1 so no false edge is seen on exit from reset.
//   - Sync: each input passes SYNC_STAGES flops. Falling edge = prev_sclk=1 & sclk_s=0.
//     Bus timing: sclk high and low each >= SYNC_STAGES+2 clk cycles.
//   - FSM IDLE -> SHIFT when fsync_s=0. In SHIFT, each falling edge shifts sdata_s into
//     the LSB and increments bit_cnt (0..16).
//   - On the 16th edge: word <= shifted value; word_valid=1 the next cycle; decode is
//     applied in that same cycle. FSM -> DONE; further edges are ignored until fsync_s=1.
//   - fsync_s=1 in SHIFT with bit_cnt 1..15: frame_err pulse; partial word discarded;
//     registers unchanged; -> IDLE. With bit_cnt=0: -> IDLE silently.
//   - DONE -> IDLE on fsync_s=1. A sclk falling edge in the same cycle as fsync rise is
//     ignored.
//   - Decode of w=word:
//     00 -> ctrl_reg<=w; clears both FREQ half-flags.
//     01 -> FREQ0 data; 10 -> FREQ1 data.
//     11, w[13]=0 -> phase0<=w[11:0]; 11, w[13]=1 -> phase1<=w[11:0].
//   - FREQ data (d=w[13:0]), using ctrl_reg[13]=B28 and ctrl_reg[12]=HLB:
//     B28=0, HLB=0: freq[13:0]<=d.
//     B28=0, HLB=1: freq[27:14]<=d.
//     B28=1, half-flag=0: d is held as pending LSBs; half-flag<=1; freq unchanged.
//     B28=1, half-flag=1: freq<={d,pending}; half-flag<=0. The 28-bit update is atomic.
//     Each FREQ register has its own half-flag and pending holder.
//   - Reset mid-frame: frame abandoned; no frame_err; FSM waits for fsync_s=1 then =0.
// TESTING
//   1. ctrl 16'h2000 (B28=1), then FREQ0 16'h50C7, 16'h4000 -> freq0=28'h00010C7, after
//      second word_valid only.
//   2. B28=0,HLB=1 ctrl 16'h1000, then 16'h8ABC -> freq1[27:14]=14'h0ABC, [13:0] unchanged.
//   3. Words 16'hC123 and 16'hE456 -> phase0=12'h123, phase1=12'h456, 2 word_valid pulses.
//   4. fsync rises after 9 bits -> one frame_err pulse, no word_valid, registers unchanged.
//   5. B28=1: one FREQ0 LSB word, then ctrl write, then FREQ0 16'h4001 -> treated as new
//      LSB; freq0 unchanged.
//   6. rst asserted at bit 8, then a full word 16'h0100 -> ctrl_reg=16'h0100 with exactly
//      one word_valid.

Source files
------------

// File: rtl/ad9833_serial_rx.sv
// rtl/ad9833_serial_rx.sv - AD9833 3-wire receiver decoding words into a shadow register file
module ad9833_serial_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fsync,
  input  logic        sclk,
  input  logic        sdata,
  output logic [15:0] word,
  output logic        word_valid,
  output logic        frame_err,
  output logic [15:0] ctrl_reg,
  output logic [27:0] freq0,
  output logic [27:0] freq1,
  output logic [11:0] phase0,
  output logic [11:0] phase1
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int SW = $clog2(SS + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SS);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t state, next_state;

  logic [SS-1:0] fsync_sr, sclk_sr, sdata_sr;
  logic          prev_sclk;
  logic [SW-1:0] settle_cnt;
  logic [15:0]   shift_q;
  logic [4:0]    bit_cnt;
  logic          half0, half1;
  logic [13:0]   pend0, pend1;

  logic        fsync_s, sclk_s, sdata_s, sclk_fall, settled;
  logic        shift_en, capture, err;
  logic [15:0] new_word;
  logic [13:0] d;

  assign fsync_s   = fsync_sr[SS-1];
  assign sclk_s    = sclk_sr[SS-1];
  assign sdata_s   = sdata_sr[SS-1];
  assign sclk_fall = prev_sclk & ~sclk_s;
  assign settled   = (settle_cnt == SETTLE_MAX);
  assign new_word  = {shift_q[14:0], sdata_s};
  assign d         = new_word[13:0];

  // Idle-high reset values keep the first cycles after reset from looking like edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsync_sr   <= '1;
      sclk_sr    <= '1;
      sdata_sr   <= '0;
      prev_sclk  <= 1'b1;
      settle_cnt <= '0;
    end else begin
      fsync_sr   <= {fsync_sr[SS-2:0], fsync};
      sclk_sr    <= {sclk_sr[SS-2:0], sclk};
      sdata_sr   <= {sdata_sr[SS-2:0], sdata};
      prev_sclk  <= sclk_s;
      if (!settled) settle_cnt <= settle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_WAIT;
    else     state <= next_state;
  end

  // ST_WAIT holds off until the synchronizers carry real bus values and fsync is
  // seen high, so a frame cut by reset is never picked up part-way.
  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    capture    = 1'b0;
    err        = 1'b0;
    case (state)
      ST_WAIT:  if (settled && fsync_s) next_state = ST_IDLE;
      ST_IDLE:  if (!fsync_s) next_state = ST_SHIFT;
      ST_SHIFT: begin
        if (fsync_s) begin
          next_state = ST_IDLE;
          err        = (bit_cnt != 5'd0);
        end else if (sclk_fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 5'd15) begin
            capture    = 1'b1;
            next_state = ST_DONE;
          end
        end
      end
      ST_DONE:  if (fsync_s) next_state = ST_IDLE;
      default:  next_state = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      ctrl_reg   <= '0;
      freq0      <= '0;
      freq1      <= '0;
      phase0     <= '0;
      phase1     <= '0;
      half0      <= 1'b0;
      half1      <= 1'b0;
      pend0      <= '0;
      pend1      <= '0;
    end else begin
      word_valid <= capture;
      frame_err  <= err;
      if (state != ST_SHIFT) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift_q <= new_word;
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (capture) begin
        word <= new_word;
        case (new_word[15:14])
          2'b00: begin
            ctrl_reg <= new_word;
            half0    <= 1'b0;
            half1    <= 1'b0;
          end
          2'b01: begin
            if (!ctrl_reg[13]) begin
              if (ctrl_reg[12]) freq0[27:14] <= d;
              else              freq0[13:0]  <= d;
            end else if (!half0) begin
              pend0 <= d;
              half0 <= 1'b1;
            end else begin
              freq0 <= {d, pend0};
              half0 <= 1'b0;
            end
          end
          2'b10: begin
            if (!ctrl_reg[13]) begin
              if (ctrl_reg[12]) freq1[27:14] <= d;
              else              freq1[13:0]  <= d;
            end else if (!half1) begin
              pend1 <= d;
              half1 <= 1'b1;
            end else begin
              freq1 <= {d, pend1};
              half1 <= 1'b0;
            end
          end
          default: begin
            if (new_word[13]) phase1 <= new_word[11:0];
            else              phase0 <= new_word[11:0];
          end
        endcase
      end
    end
  end

endmodule
